count_window_cmp: RTL



---
 rtl/cmp_pkg.sv | 12 +
 rtl/cmp_qual_filter.sv | 58 +++++
 rtl/count_window_cmp.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - zone encodings shared by the window comparator and its filter
package cmp_pkg;

  localparam int ZONE_W = 2;

  typedef enum logic [ZONE_W-1:0] {
    ZONE_BELOW  = 2'b00,
    ZONE_INSIDE = 2'b01,
    ZONE_ABOVE  = 2'b10
  } zone_e;

endpackage

// File: rtl/cmp_qual_filter.sv
// rtl/cmp_qual_filter.sv - persistence filter, strobes accept after QUAL stable cycles
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : evaluation enable; low holds the run counter at 0
//   clr        : clears the run counter (threshold reload), suppresses accept
//   cand       : candidate zone this cycle
//   zone       : currently accepted zone
//   accept     : combinational strobe; the owner registers cand into zone on this edge
module cmp_qual_filter
  import cmp_pkg::*;
#(
  parameter int QUAL = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [ZONE_W-1:0] cand,
  input  logic [ZONE_W-1:0] zone,
  output logic              accept
);

  localparam int CNT_W = (QUAL < 2) ? 1 : $clog2(QUAL + 1);
  localparam logic [CNT_W-1:0] QUAL_C = CNT_W'(QUAL);

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic [ZONE_W-1:0] prev_cand_q;

  // A candidate that differs from last cycle's starts a fresh run of 1;
  // the counter never exceeds QUAL because reaching it clears it.
  always_comb begin
    cnt_inc = (cand == prev_cand_q) ? cnt_q + CNT_W'(1) : CNT_W'(1);
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (!en || clr || (cand == zone)) begin
      cnt_d = '0;
    end else if (cnt_inc == QUAL_C) begin
      accept = 1'b1;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      prev_cand_q <= ZONE_BELOW;
    end else begin
      cnt_q       <= cnt_d;
      prev_cand_q <= cand;
    end
  end

endmodule

// File: rtl/count_window_cmp.sv
// rtl/count_window_cmp.sv - windowed comparator with hysteresis, qualification and dwell
//
// Optional feature macro: CMP_DWELL_EN builds the dwell-time counter; when
// undefined, dwell is tied to 0.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   en              : evaluation enable
//   count           : unsigned counter value to classify
//   thr_load        : load request for thr_lo/thr_hi (rejected if lo > hi)
//   thr_lo, thr_hi  : inclusive window bounds
//   zone            : 00 BELOW, 01 INSIDE, 10 ABOVE
//   enter_p, exit_p : one-cycle pulses on entering / leaving INSIDE
//   cfg_err         : sticky flag for a rejected threshold load
//   dwell           : cycles spent INSIDE, saturating
module count_window_cmp
  import cmp_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int HYST    = 2,
  parameter int QUAL    = 3,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [WIDTH-1:0]   count,
  input  logic               thr_load,
  input  logic [WIDTH-1:0]   thr_lo,
  input  logic [WIDTH-1:0]   thr_hi,
  output logic [ZONE_W-1:0]  zone,
  output logic               enter_p,
  output logic               exit_p,
  output logic               cfg_err,
  output logic [DWELL_W-1:0] dwell
);

  // Two extra bits keep bound +/- HYST from wrapping and allow a sign.
  localparam int SW = WIDTH + 2;
  localparam logic signed [SW-1:0] HYST_S = SW'(HYST);

  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  zone_e            zone_q;
  zone_e            cand;
  logic             load_ok;
  logic             accept;

  logic signed [SW-1:0] cnt_s;
  logic signed [SW-1:0] lo_s;
  logic signed [SW-1:0] hi_s;

  assign load_ok = thr_load && (thr_lo <= thr_hi);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q    <= '0;
      hi_q    <= '1;
      cfg_err <= 1'b0;
    end else if (thr_load) begin
      if (load_ok) begin
        lo_q    <= thr_lo;
        hi_q    <= thr_hi;
        cfg_err <= 1'b0;
      end else begin
        cfg_err <= 1'b1;
      end
    end
  end

  // Entry into INSIDE needs the count HYST past the bound; leaving INSIDE
  // happens at the bound itself, so small reversals do not chatter.
  always_comb begin
    cnt_s = $signed({2'b00, count});
    lo_s  = $signed({2'b00, lo_q});
    hi_s  = $signed({2'b00, hi_q});
    cand  = zone_q;
    unique case (zone_q)
      ZONE_BELOW: begin
        if (cnt_s > hi_s + HYST_S)       cand = ZONE_ABOVE;
        else if (cnt_s >= lo_s + HYST_S) cand = ZONE_INSIDE;
        else                             cand = ZONE_BELOW;
      end
      ZONE_INSIDE: begin
        if (cnt_s < lo_s)      cand = ZONE_BELOW;
        else if (cnt_s > hi_s) cand = ZONE_ABOVE;
        else                   cand = ZONE_INSIDE;
      end
      ZONE_ABOVE: begin
        if (cnt_s < lo_s - HYST_S)       cand = ZONE_BELOW;
        else if (cnt_s <= hi_s - HYST_S) cand = ZONE_INSIDE;
        else                             cand = ZONE_ABOVE;
      end
      default: cand = ZONE_BELOW;
    endcase
  end

  cmp_qual_filter #(
    .QUAL (QUAL)
  ) u_qual (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .clr    (load_ok),
    .cand   (cand),
    .zone   (zone_q),
    .accept (accept)
  );

  // A direct BELOW<->ABOVE jump never touches INSIDE, so it pulses nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zone_q  <= ZONE_BELOW;
      enter_p <= 1'b0;
      exit_p  <= 1'b0;
    end else begin
      enter_p <= accept && (cand == ZONE_INSIDE);
      exit_p  <= accept && (zone_q == ZONE_INSIDE);
      if (accept) zone_q <= cand;
    end
  end

  assign zone = zone_q;

`ifdef CMP_DWELL_EN
  logic [DWELL_W-1:0] dwell_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q <= '0;
    end else if (accept && (cand == ZONE_INSIDE)) begin
      dwell_q <= '0;
    end else if (en && (zone_q == ZONE_INSIDE) && (dwell_q != '1)) begin
      dwell_q <= dwell_q + DWELL_W'(1);
    end
  end

  assign dwell = dwell_q;
`else
  assign dwell = '0;
`endif

endmodule
